// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, decode handoff
// One fetch outstanding; next PC resolved from the presented instruction on consume.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic        PCJ,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic [31:0] retired_q;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc_d;

    // Redirect targets are relative to the held instruction, not the fetch PC.
    always_comb begin
        pc4    = instr_pc_q + 32'd4;
        br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (PCJ)
            next_pc_d = {pc4[31:28], instr_q[25:0], 2'b00};
        else if (PCSrc)
            next_pc_d = pc4 + br_off;
        else
            next_pc_d = pc4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= 32'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_q    <= HOLD;
                        req_q      <= 1'b0;
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    // Issuing the next request from here keeps redirects penalty-free.
                    if (valid_q && instr_ready) begin
                        state_q   <= FETCH;
                        pc_q      <= next_pc_d;
                        req_q     <= 1'b1;
                        addr_q    <= next_pc_d;
                        valid_q   <= 1'b0;
                        retired_q <= retired_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        PCSrc;
    logic        PCJ;
    logic        sel;

    logic        a_req, b_req, a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_instr, b_instr, a_ipc, b_ipc, a_ret, b_ret;
    logic [5:0]  a_op, b_op, a_fn, b_fn;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc, retired;
    logic [5:0]  opcode, func;

    int pass_cnt;
    int total_cnt;

    // Second instance boots in the 0x3 region so the jump case is reachable.
    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(imem_ack & ~sel), .imem_rdata(imem_rdata),
        .instr(a_instr), .opcode(a_op), .func(a_fn), .instr_pc(a_ipc),
        .instr_valid(a_valid), .instr_ready(instr_ready & ~sel),
        .PCSrc(PCSrc), .PCJ(PCJ), .retired(a_ret)
    );

    instr_fetch_unit #(.RESET_PC(32'h3000_0010)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(imem_ack & sel), .imem_rdata(imem_rdata),
        .instr(b_instr), .opcode(b_op), .func(b_fn), .instr_pc(b_ipc),
        .instr_valid(b_valid), .instr_ready(instr_ready & sel),
        .PCSrc(PCSrc), .PCJ(PCJ), .retired(b_ret)
    );

    assign imem_req    = sel ? b_req   : a_req;
    assign imem_addr   = sel ? b_addr  : a_addr;
    assign instr       = sel ? b_instr : a_instr;
    assign opcode      = sel ? b_op    : a_op;
    assign func        = sel ? b_fn    : a_fn;
    assign instr_pc    = sel ? b_ipc   : a_ipc;
    assign instr_valid = sel ? b_valid : a_valid;
    assign retired     = sel ? b_ret   : a_ret;

    always #5 clk = ~clk;

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!ok) $display("FAIL %s: imem_req got 0 expected 1 within 20 cycles", name);
        else pass_cnt++;
    endtask

    task automatic give(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hx;
    endtask

    task automatic consume(input logic src, input logic j);
        instr_ready = 1'b1;
        PCSrc       = src;
        PCJ         = j;
        @(negedge clk);
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCJ         = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({imem_req, instr_valid} !== 2'b00) $display("FAIL rst_ctl: got %b expected 00", {imem_req, instr_valid});
        else pass_cnt++;
        total_cnt++;
        if ({imem_addr, instr, instr_pc, retired} !== 128'd0)
            $display("FAIL rst_data: got %h %h %h %h expected all 0", imem_addr, instr, instr_pc, retired);
        else pass_cnt++;
        total_cnt++;
        if ({opcode, func} !== 12'd0) $display("FAIL rst_fields: got %h expected 000", {opcode, func});
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL idle_req: got %b expected 0", imem_req);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL boot_fetch: got req %b addr %h expected 1 00000100", imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_boot;
        logic [31:0] words [3];
        logic [5:0]  ops   [3];
        logic [5:0]  fns   [3];
        logic [31:0] exp_pc;
        words[0] = 32'h012A_4020; ops[0] = 6'h00; fns[0] = 6'h20;
        words[1] = 32'h8D09_0004; ops[1] = 6'h23; fns[1] = 6'h04;
        words[2] = 32'hAD09_0008; ops[2] = 6'h2B; fns[2] = 6'h08;
        exp_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            wait_req("boot_req");
            total_cnt++;
            if (imem_addr !== exp_pc || instr_valid !== 1'b0)
                $display("FAIL boot_addr%0d: got %h valid %b expected %h valid 0", i, imem_addr, instr_valid, exp_pc);
            else pass_cnt++;
            give(words[i]);
            total_cnt++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== words[i] || instr_pc !== exp_pc)
                $display("FAIL boot_hold%0d: got v%b r%b %h @%h expected v1 r0 %h @%h",
                         i, instr_valid, imem_req, instr, instr_pc, words[i], exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (opcode !== ops[i] || func !== fns[i])
                $display("FAIL boot_fields%0d: got %h/%h expected %h/%h", i, opcode, func, ops[i], fns[i]);
            else pass_cnt++;
            consume(1'b0, 1'b0);
            exp_pc = exp_pc + 32'd4;
        end
        total_cnt++;
        if (retired !== 32'd3 || imem_addr !== 32'h10C)
            $display("FAIL boot_end: got ret %0d addr %h expected 3 0000010c", retired, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_wait_states;
        logic [31:0] a;
        wait_req("ws_req");
        a = imem_addr;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10C || instr_valid !== 1'b0)
                $display("FAIL ws_hold%0d: got r%b %h v%b expected r1 0000010c v0", k, imem_req, imem_addr, instr_valid);
            else pass_cnt++;
            if (k < 3) @(negedge clk);
        end
        give(32'h2008_0005);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== a || imem_req !== 1'b0)
            $display("FAIL ws_done: got v%b @%h r%b expected v1 @%h r0", instr_valid, instr_pc, imem_req, a);
        else pass_cnt++;
        consume(1'b0, 1'b0);
    endtask

    task automatic test_branch;
        give(32'h0800_0080);
        consume(1'b0, 1'b1);
        total_cnt++;
        if (imem_addr !== 32'h200) $display("FAIL br_setup: got %h expected 00000200", imem_addr);
        else pass_cnt++;
        give(32'h1000_FFFE);
        consume(1'b1, 1'b0);
        total_cnt++;
        if (imem_addr !== 32'h1FC || imem_req !== 1'b1) $display("FAIL br_taken: got %h expected 000001fc", imem_addr);
        else pass_cnt++;
        give(32'h0800_0080);
        consume(1'b0, 1'b1);
        give(32'h1000_FFFE);
        consume(1'b0, 1'b0);
        total_cnt++;
        if (imem_addr !== 32'h204) $display("FAIL br_not_taken: got %h expected 00000204", imem_addr);
        else pass_cnt++;
        total_cnt++;
        if (retired !== 32'd8) $display("FAIL br_retired: got %0d expected 8", retired);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        give(32'h0000_0000);
        PCJ = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h204 ||
                instr !== 32'h0 || retired !== 32'd8 || imem_addr !== 32'h204)
                $display("FAIL bp_stall%0d: got v%b r%b @%h ret %0d expected v1 r0 @00000204 ret 8",
                         k, instr_valid, imem_req, instr_pc, retired);
            else pass_cnt++;
        end
        PCJ = 1'b0;
        consume(1'b0, 1'b0);
        total_cnt++;
        if (imem_addr !== 32'h208 || retired !== 32'd9)
            $display("FAIL bp_release: got %h ret %0d expected 00000208 ret 9", imem_addr, retired);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        give(32'h0800_0000);
        consume(1'b0, 1'b1);
        give(32'h1000_FFFE);
        consume(1'b1, 1'b0);
        total_cnt++;
        if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h expected fffffffc", imem_addr);
        else pass_cnt++;
        give(32'h0000_0000);
        total_cnt++;
        if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ipc: got %h expected fffffffc", instr_pc);
        else pass_cnt++;
        consume(1'b0, 1'b0);
        total_cnt++;
        if (imem_addr !== 32'h0 || retired !== 32'd12)
            $display("FAIL wrap_seq: got %h ret %0d expected 00000000 ret 12", imem_addr, retired);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fetch;
        total_cnt++;
        if (imem_req !== 1'b1) $display("FAIL mid_pre: got req %b expected 1", imem_req);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({imem_req, instr_valid} !== 2'b00 || {imem_addr, instr, instr_pc, retired} !== 128'd0 ||
            {opcode, func} !== 12'd0)
            $display("FAIL mid_clear: got r%b v%b %h %h %h %h expected all 0",
                     imem_req, instr_valid, imem_addr, instr, instr_pc, retired);
        else pass_cnt++;
        @(negedge clk);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0 || instr !== 32'h0)
            $display("FAIL mid_restart: got r%b %h v%b %h expected r1 00000100 v0 00000000",
                     imem_req, imem_addr, instr_valid, instr);
        else pass_cnt++;
        give(32'h2402_000A);
        total_cnt++;
        if (instr !== 32'h2402_000A || instr_pc !== 32'h100)
            $display("FAIL mid_fetch: got %h @%h expected 2402000a @00000100", instr, instr_pc);
        else pass_cnt++;
        consume(1'b0, 1'b0);
        total_cnt++;
        if (retired !== 32'd1 || imem_addr !== 32'h104)
            $display("FAIL mid_retire: got %0d %h expected 1 00000104", retired, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_jump;
        sel = 1'b1;
        #1;
        wait_req("jmp_req");
        total_cnt++;
        if (imem_addr !== 32'h3000_0010) $display("FAIL jmp_boot: got %h expected 30000010", imem_addr);
        else pass_cnt++;
        give(32'h0800_0040);
        consume(1'b1, 1'b1);
        total_cnt++;
        if (imem_addr !== 32'h3000_0100 || retired !== 32'd1)
            $display("FAIL jmp_target: got %h ret %0d expected 30000100 ret 1", imem_addr, retired);
        else pass_cnt++;
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCJ         = 1'b0;
        sel         = 1'b0;
        pass_cnt    = 0;
        total_cnt   = 0;
        test_reset;
        test_boot;
        test_wait_states;
        test_branch;
        test_backpressure;
        test_wrap;
        test_reset_mid_fetch;
        test_jump;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
